pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 16 +
 rtl/fwd_sel.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: operand forward selects
// and the multicycle hold FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// One operand's forwarding decision: the youngest in-flight writer wins, so
// Memory takes priority over Writeback; x0 is never forwarded.
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_w,
  output logic [1:0]        sel
);

  fwd_sel_t sel_enc;

  // Priority compare: Memory stage result before Writeback result.
  always_comb begin
    sel_enc = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      sel_enc = FWD_MEM;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      sel_enc = FWD_WB;
    end
  end

  assign sel = sel_enc;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use stall,
// branch flush, multicycle-op hold with timeout, optional perf counters.
// Optional feature macro: PIPE_PERF_EN (stall/flush cycle counters).
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              load_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              pcsrc_e,
  input  logic              mc_req_e,
  input  logic              mc_done,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mc_go,
  output logic              mc_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned TO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  hz_state_t       state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            load_use;
  logic            mc_hold;

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs         (rs1_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .sel        (forward_a_e)
  );

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs         (rs2_e),
    .rd_m       (rd_m),
    .regwrite_m (regwrite_m),
    .rd_w       (rd_w),
    .regwrite_w (regwrite_w),
    .sel        (forward_b_e)
  );

  assign load_use = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Multicycle FSM next state, start/timeout pulses and the pipe-hold request.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    mc_hold  = 1'b0;
    mc_go    = 1'b0;
    mc_err   = 1'b0;
    case (state_q)
      RUN: begin
        // E never stalls in RUN, so every RUN cycle with mc_req_e is a new op.
        if (mc_req_e) begin
          mc_go = 1'b1;
          if (!pcsrc_e && !mc_done) begin
            state_d  = MC_WAIT;
            to_cnt_d = '0;
            mc_hold  = 1'b1;
          end
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_d = RUN;
        end else if (to_cnt_q == TO_LAST) begin
          mc_err  = 1'b1;
          state_d = RUN;
        end else begin
          mc_hold  = 1'b1;
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      state_d  = RUN;
      to_cnt_d = '0;
      mc_hold  = 1'b0;
      mc_go    = 1'b0;
      mc_err   = 1'b0;
    end
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Stall/flush decode; a taken branch beats load-use, a multicycle hold
  // already freezes D so the load-use bubble is not needed.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (!rst) begin
      stall_f = mc_hold || (load_use && !pcsrc_e);
      stall_d = mc_hold || (load_use && !pcsrc_e);
      stall_e = mc_hold;
      flush_m = mc_hold;
      flush_d = pcsrc_e;
      flush_e = pcsrc_e || (load_use && !mc_hold);
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_e && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed literal checks followed
// by randomized stimulus compared every cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned MC_TIMEOUT = 8;
  localparam int unsigned CNT_W      = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              load_e, regwrite_m, regwrite_w, pcsrc_e, mc_req_e, mc_done;
  logic [1:0]        forward_a_e, forward_b_e;
  logic              stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
  logic              mc_go, mc_err;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // Model state: are we holding for a multicycle op, how many wait cycles so far.
  bit m_wait   = 1'b0;
  int m_waited = 0;
  int m_scnt   = 0;
  int m_fcnt   = 0;

  pipe_hazard_ctrl #(
    .REG_AW     (REG_AW),
    .MC_TIMEOUT (MC_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rs1_e       (rs1_e),
    .rs2_e       (rs2_e),
    .rd_e        (rd_e),
    .load_e      (load_e),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .regwrite_m  (regwrite_m),
    .regwrite_w  (regwrite_w),
    .pcsrc_e     (pcsrc_e),
    .mc_req_e    (mc_req_e),
    .mc_done     (mc_done),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .stall_e     (stall_e),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .flush_m     (flush_m),
    .mc_go       (mc_go),
    .mc_err      (mc_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int fwd(input int rs, input int rdm, input bit wm, input int rdw,
                             input bit ww);
    if (wm && rdm != 0 && rdm == rs) return 2;
    if (ww && rdw != 0 && rdw == rs) return 1;
    return 0;
  endfunction

  // Compare process: evaluate the rules for this cycle, check, then advance.
  always @(negedge clk) begin : cmp
    bit lu, hold, go, err, done_now, tmo, enter;
    bit e_sf, e_se, e_fd, e_fe, e_fm;
    lu = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    hold = 0; go = 0; err = 0; done_now = 0; tmo = 0; enter = 0;
    if (!m_wait) begin
      go    = mc_req_e;
      enter = mc_req_e && !pcsrc_e && !mc_done;
      hold  = enter;
    end else begin
      done_now = mc_done;
      tmo      = !mc_done && (m_waited == MC_TIMEOUT - 1);
      hold     = !done_now && !tmo;
      err      = tmo;
    end
    if (rst) begin
      hold = 0; go = 0; err = 0;
    end
    e_sf = !rst && (hold || (lu && !pcsrc_e));
    e_se = !rst && hold;
    e_fm = !rst && hold;
    e_fd = !rst && pcsrc_e;
    e_fe = !rst && (pcsrc_e || (lu && !hold));
    if (check_en) begin
      chk("forward_a_e", int'(forward_a_e), fwd(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w));
      chk("forward_b_e", int'(forward_b_e), fwd(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w));
      chk("stall_f", int'(stall_f), int'(e_sf));
      chk("stall_d", int'(stall_d), int'(e_sf));
      chk("stall_e", int'(stall_e), int'(e_se));
      chk("flush_d", int'(flush_d), int'(e_fd));
      chk("flush_e", int'(flush_e), int'(e_fe));
      chk("flush_m", int'(flush_m), int'(e_fm));
      chk("mc_go", int'(mc_go), int'(go));
      chk("mc_err", int'(mc_err), int'(err));
`ifdef PIPE_PERF_EN
      chk("stall_cnt", int'(stall_cnt), m_scnt);
      chk("flush_cnt", int'(flush_cnt), m_fcnt);
`else
      chk("stall_cnt", int'(stall_cnt), 0);
      chk("flush_cnt", int'(flush_cnt), 0);
`endif
    end
    if (rst) begin
      m_wait = 0; m_waited = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (!m_wait) begin
        if (enter) begin m_wait = 1; m_waited = 0; end
      end else if (done_now || tmo) begin
        m_wait = 0;
      end else begin
        m_waited++;
      end
      if (e_sf && m_scnt < CNT_MAX) m_scnt++;
      if (e_fe && m_fcnt < CNT_MAX) m_fcnt++;
    end
  end

  task automatic idle_in();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    load_e = 0; regwrite_m = 0; regwrite_w = 0; pcsrc_e = 0; mc_req_e = 0; mc_done = 0;
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    idle_in();
    cyc();
    check_en = 1;
    // Reset: outputs idle except forwarding, which stays combinational.
    rd_m = 5; regwrite_m = 1; rs1_e = 5;
    load_e = 1; rd_e = 7; rs2_d = 7; mc_req_e = 1;
    #2;
    chk("rst fwd_a", int'(forward_a_e), 2);
    chk("rst stall_f", int'(stall_f), 0);
    chk("rst flush_e", int'(flush_e), 0);
    chk("rst mc_go", int'(mc_go), 0);
    chk("rst stall_cnt", int'(stall_cnt), 0);
    cyc();
    rst = 0; idle_in();

    // Forwarding priority.
    rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs1_e = 5; rs2_e = 5;
    #2;
    chk("fwd mem wins a", int'(forward_a_e), 2);
    chk("fwd mem wins b", int'(forward_b_e), 2);
    cyc();
    rd_m = 0;
    #2;
    chk("fwd wb a", int'(forward_a_e), 1);
    cyc();
    idle_in();

    // Load-use, then load-use with a taken branch.
    load_e = 1; rd_e = 7; rs2_d = 7;
    #2;
    chk("lu stall_f", int'(stall_f), 1);
    chk("lu stall_d", int'(stall_d), 1);
    chk("lu flush_e", int'(flush_e), 1);
    chk("lu stall_e", int'(stall_e), 0);
    cyc();
    pcsrc_e = 1;
    #2;
    chk("br flush_d", int'(flush_d), 1);
    chk("br flush_e", int'(flush_e), 1);
    chk("br stall_f", int'(stall_f), 0);
    cyc();
    idle_in();
    #2;
    chk("lu released", int'(stall_f), 0);
    cyc();

    // Multicycle op completing on the fifth wait cycle.
    mc_req_e = 1;
    for (int i = 0; i <= 5; i++) begin
      mc_done = (i == 5);
      #2;
      chk("mc go", int'(mc_go), (i == 0) ? 1 : 0);
      chk("mc stall_e", int'(stall_e), (i < 5) ? 1 : 0);
      chk("mc flush_m", int'(flush_m), (i < 5) ? 1 : 0);
      cyc();
    end
    idle_in();

    // Timeout: no mc_done ever.
    mc_req_e = 1;
    for (int i = 0; i <= 8; i++) begin
      #2;
      chk("to stall_f", int'(stall_f), (i < 8) ? 1 : 0);
      chk("to mc_err", int'(mc_err), (i == 8) ? 1 : 0);
      cyc();
      if (i == 8) mc_req_e = 0;
    end
    #2;
    chk("to back in run", int'(mc_err) + int'(stall_f), 0);
    cyc();

    // Reset while holding for a multicycle op.
    mc_req_e = 1;
    cyc(); cyc(); cyc();
    rst = 1;
    #2;
    chk("rst mid wait stall_f", int'(stall_f), 0);
    chk("rst mid wait flush_m", int'(flush_m), 0);
    cyc();
    rst = 0;
    #2;
    chk("post rst mc_go", int'(mc_go), 1);
    chk("post rst stall_cnt", int'(stall_cnt), 0);
    chk("post rst flush_cnt", int'(flush_cnt), 0);
    cyc();
    mc_done = 1;
    #2;
    chk("post rst release", int'(stall_f), 0);
    cyc();
    idle_in();

    // Counter saturation with 20 load-use stalls.
    load_e = 1; rd_e = 3; rs1_d = 3;
    repeat (20) cyc();
    idle_in();
    #2;
`ifdef PIPE_PERF_EN
    chk("stall_cnt sat", int'(stall_cnt), 15);
    chk("flush_cnt sat", int'(flush_cnt), 15);
`else
    chk("stall_cnt off", int'(stall_cnt), 0);
    chk("flush_cnt off", int'(flush_cnt), 0);
`endif
    cyc();

    // Randomized phase.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      rs1_d      = REG_AW'($urandom_range(0, 3));
      rs2_d      = REG_AW'($urandom_range(0, 3));
      rs1_e      = REG_AW'($urandom_range(0, 3));
      rs2_e      = REG_AW'($urandom_range(0, 3));
      rd_e       = REG_AW'($urandom_range(0, 3));
      rd_m       = REG_AW'($urandom_range(0, 3));
      rd_w       = REG_AW'($urandom_range(0, 3));
      load_e     = ($urandom_range(0, 2) == 0);
      regwrite_m = $urandom_range(0, 1) != 0;
      regwrite_w = $urandom_range(0, 1) != 0;
      pcsrc_e    = ($urandom_range(0, 7) == 0);
      mc_req_e   = ($urandom_range(0, 3) == 0);
      mc_done    = ($urandom_range(0, 5) == 0);
      cyc();
    end
    rst = 0;
    idle_in();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
